// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Write-back arbiter. Picks one result-producing unit per cycle
//             (fixed priority or round-robin), registers the accepted result
//             and drives the register-file write port one cycle later.
//             Results targeting x0 are consumed but produce no write.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1                 clock, rising edge
//    rst          in   1                 asynchronous reset, active low
//    src_valid    in   NUM_SRC           per-unit result valid
//    src_ready    out  NUM_SRC           per-unit accept (combinational)
//    src_rd_addr  in   NUM_SRC*5         per-unit destination register
//    src_data     in   NUM_SRC*DATA_W    per-unit result value
//    wb_stall     in   1                 register-file port busy this cycle
//    rf_we        out  1                 register-file write enable
//    rf_waddr     out  5                 register-file write address
//    rf_wdata     out  DATA_W            register-file write data
//    wb_src_id    out  SRC_ID_W          unit that produced the current write
//    wb_count     out  32                committed writes; a write is counted
//                                        at the clock edge that ends its
//                                        rf_we cycle
// ============================================================================
module wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int NUM_SRC  = 2,
  parameter int RR_MODE  = 0,
  localparam int SRC_ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*5-1:0]      src_rd_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      wb_stall,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [SRC_ID_W-1:0]       wb_src_id,
  output logic [31:0]               wb_count
);

  localparam logic [SRC_ID_W-1:0] c_last_idx = SRC_ID_W'(NUM_SRC - 1);

  // Registered state
  logic                rf_we_q,     rf_we_d;
  logic [4:0]          rf_waddr_q,  rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q,  rf_wdata_d;
  logic [SRC_ID_W-1:0] wb_src_id_q, wb_src_id_d;
  logic [31:0]         wb_count_q,  wb_count_d;
  logic [SRC_ID_W-1:0] rr_ptr_q;

  // Arbitration wires
  int                  w_ptr_int;
  logic                w_hi_found, w_lo_found;
  logic [SRC_ID_W-1:0] w_hi_idx,   w_lo_idx;
  logic                w_grant_valid;
  logic [SRC_ID_W-1:0] w_grant_idx;
  logic                w_xfer;
  logic [4:0]          w_sel_rd;
  logic [DATA_W-1:0]   w_sel_data;

  assign w_ptr_int = int'(rr_ptr_q);

  // Round-robin search without a rotator: the lowest valid index at or above
  // the pointer wins; if none exists the search has wrapped, so the lowest
  // valid index overall wins. With the pointer pinned at 0 this collapses to
  // plain fixed priority. Descending scan leaves the lowest match last.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (src_valid[j]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = SRC_ID_W'(j);
        if (j >= w_ptr_int) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SRC_ID_W'(j);
        end
      end
    end
    w_grant_valid = w_hi_found | w_lo_found;
    w_grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // A grant only turns into a transfer while out of reset and not stalled.
  assign w_xfer = rst & ~wb_stall & w_grant_valid;

  always_comb begin
    src_ready  = '0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (w_grant_idx == SRC_ID_W'(j)) begin
        src_ready[j] = w_xfer;
        w_sel_rd     = src_rd_addr[j*5 +: 5];
        w_sel_data   = src_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for the write-back stage. A result for x0 is still consumed
  // (the unit sees ready) but leaves the write port fully quiet.
  always_comb begin
    rf_we_d     = 1'b0;
    rf_waddr_d  = '0;
    rf_wdata_d  = '0;
    wb_src_id_d = wb_src_id_q;
    if (w_xfer) begin
      wb_src_id_d = w_grant_idx;
      if (w_sel_rd != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = w_sel_rd;
        rf_wdata_d = w_sel_data;
      end
    end
    wb_count_d = wb_count_q + {31'd0, rf_we_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      wb_src_id_q <= '0;
      wb_count_q  <= '0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      wb_src_id_q <= wb_src_id_d;
      wb_count_q  <= wb_count_d;
    end
  end

  generate
    if (RR_MODE != 0) begin : g_rr
      logic [SRC_ID_W-1:0] rr_ptr_d;

      // Pointer moves just past the winner, and only when something moved.
      always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_xfer) begin
          rr_ptr_d = (w_grant_idx == c_last_idx) ? '0
                                                 : w_grant_idx + SRC_ID_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rr_ptr_q <= '0;
        end else begin
          rr_ptr_q <= rr_ptr_d;
        end
      end
    end else begin : g_fixed
      assign rr_ptr_q = '0;
    end
  endgenerate

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign wb_src_id = wb_src_id_q;
  assign wb_count  = wb_count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Self-checking bench. dut0 = 2 units, fixed priority;
//             dut1 = 3 units, round-robin. A queue-free behavioural model
//             predicts every output each cycle; directed sequences pin the
//             model with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic [1:0]  v0 = '0;
  logic [1:0]  rdy0;
  logic [9:0]  rd0 = '0;
  logic [63:0] d0 = '0;
  logic        st0 = 1'b0;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic [0:0]  id0;
  logic [31:0] cnt0;

  // dut1 signals
  logic [2:0]  v1 = '0;
  logic [2:0]  rdy1;
  logic [14:0] rd1 = '0;
  logic [95:0] d1 = '0;
  logic        st1 = 1'b0;
  logic        we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic [1:0]  id1;
  logic [31:0] cnt1;

  wb_arbiter #(.DATA_W(32), .NUM_SRC(2), .RR_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .src_valid(v0), .src_ready(rdy0),
    .src_rd_addr(rd0), .src_data(d0), .wb_stall(st0),
    .rf_we(we0), .rf_waddr(wa0), .rf_wdata(wd0),
    .wb_src_id(id0), .wb_count(cnt0)
  );

  wb_arbiter #(.DATA_W(32), .NUM_SRC(3), .RR_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .src_valid(v1), .src_ready(rdy1),
    .src_rd_addr(rd1), .src_data(d1), .wb_stall(st1),
    .rf_we(we1), .rf_waddr(wa1), .rf_wdata(wd1),
    .wb_src_id(id1), .wb_count(cnt1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr [2];
  logic        m_we  [2];
  logic [4:0]  m_wa  [2];
  logic [31:0] m_wd  [2];
  logic [31:0] m_id  [2];
  logic [31:0] m_cnt [2];

  function automatic int n_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic logic get_v(input int d, input int k);
    return (d == 0) ? v0[k] : v1[k];
  endfunction

  function automatic logic [4:0] get_rd(input int d, input int k);
    return (d == 0) ? rd0[k*5 +: 5] : rd1[k*5 +: 5];
  endfunction

  function automatic logic [31:0] get_data(input int d, input int k);
    return (d == 0) ? d0[k*32 +: 32] : d1[k*32 +: 32];
  endfunction

  function automatic logic get_st(input int d);
    return (d == 0) ? st0 : st1;
  endfunction

  // First valid unit walking upward from the start point with wrap; -1 if none.
  function automatic int pick(input int d);
    int n;
    int start;
    n = n_of(d);
    start = (d == 0) ? 0 : m_ptr[d];
    for (int i = 0; i < n; i++) begin
      if (get_v(d, (start + i) % n)) return (start + i) % n;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_ready(input int d);
    int g;
    logic [31:0] r;
    r = 32'd0;
    if (rst && !get_st(d)) begin
      g = pick(d);
      if (g >= 0) r = 32'd1 << g;
    end
    return r;
  endfunction

  task automatic model_reset(input int d);
    m_ptr[d] = 0;
    m_we[d]  = 1'b0;
    m_wa[d]  = '0;
    m_wd[d]  = '0;
    m_id[d]  = '0;
    m_cnt[d] = '0;
  endtask

  always @(negedge rst) begin
    model_reset(0);
    model_reset(1);
  end

  always @(posedge clk) begin
    int g;
    logic [4:0] a;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        model_reset(d);
      end else begin
        if (m_we[d]) m_cnt[d] = m_cnt[d] + 32'd1;
        g = pick(d);
        if (!get_st(d) && g >= 0) begin
          a = get_rd(d, g);
          m_we[d] = (a != 5'd0);
          m_wa[d] = a;
          m_wd[d] = (a != 5'd0) ? get_data(d, g) : 32'd0;
          m_id[d] = g;
          if (d == 1) m_ptr[d] = (g + 1) % n_of(d);
        end else begin
          m_we[d] = 1'b0;
          m_wa[d] = '0;
          m_wd[d] = '0;
        end
      end
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("ready0", 32'(rdy0), exp_ready(0));
    chk("we0",    32'(we0),  32'(m_we[0]));
    chk("waddr0", 32'(wa0),  32'(m_wa[0]));
    chk("wdata0", wd0,       m_wd[0]);
    chk("srcid0", 32'(id0),  m_id[0]);
    chk("count0", cnt0,      m_cnt[0]);
    chk("ready1", 32'(rdy1), exp_ready(1));
    chk("we1",    32'(we1),  32'(m_we[1]));
    chk("waddr1", 32'(wa1),  32'(m_wa[1]));
    chk("wdata1", wd1,       m_wd[1]);
    chk("srcid1", 32'(id1),  m_id[1]);
    chk("count1", cnt1,      m_cnt[1]);
    chk("rrptr1", 32'(dut1.rr_ptr_q), 32'(m_ptr[1]));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Random traffic that respects the hold-until-accepted rule.
  task automatic rand_phase(input int ncyc);
    logic [1:0] acc0;
    logic [2:0] acc1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      #1;
      acc0 = rdy0 & v0;
      acc1 = rdy1 & v1;
      step();
      for (int k = 0; k < 2; k++) begin
        if (acc0[k] || !v0[k]) begin
          v0[k] = ($urandom_range(0, 3) != 0);
          rd0[k*5 +: 5] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          d0[k*32 +: 32] = $urandom;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (acc1[k] || !v1[k]) begin
          v1[k] = ($urandom_range(0, 2) != 0);
          rd1[k*5 +: 5] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          d1[k*32 +: 32] = $urandom;
        end
      end
      st0 = ($urandom_range(0, 3) == 0);
      st1 = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic idle_all();
    v0 = '0; v1 = '0; st0 = 1'b0; st1 = 1'b0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    repeat (3) step();
    #1;
    chk("reset_count0", cnt0, 32'd0);
    chk("reset_we1", 32'(we1), 32'd0);
    rst = 1'b1;

    // Fixed priority, both units valid for two cycles
    step();
    v0 = 2'b11; rd0 = {5'd5, 5'd3}; d0 = {32'hBB, 32'hAA};
    #1 chk("fp_ready_c1", 32'(rdy0), 32'h1);
    step();
    #1 chk("fp_ready_c2", 32'(rdy0), 32'h1);
    chk("fp_we_c2", 32'(we0), 32'd1);
    chk("fp_waddr_c2", 32'(wa0), 32'd3);
    chk("fp_wdata_c2", wd0, 32'hAA);
    step();
    v0 = 2'b00;
    #1 chk("fp_we_c3", 32'(we0), 32'd1);
    chk("fp_wdata_c3", wd0, 32'hAA);
    step();
    #1 chk("fp_we_c4", 32'(we0), 32'd0);
    chk("fp_count", cnt0, 32'd2);

    // Round-robin, all three units valid for four cycles
    step();
    v1 = 3'b111; rd1 = {5'd3, 5'd2, 5'd1}; d1 = {32'd3, 32'd2, 32'd1};
    #1 chk("rr_grant0", 32'(rdy1), 32'h1);
    step();
    #1 chk("rr_grant1", 32'(rdy1), 32'h2);
    chk("rr_id0", 32'(id1), 32'd0);
    step();
    #1 chk("rr_grant2", 32'(rdy1), 32'h4);
    chk("rr_id1", 32'(id1), 32'd1);
    step();
    #1 chk("rr_grant3", 32'(rdy1), 32'h1);
    chk("rr_id2", 32'(id1), 32'd2);
    step();
    v1 = 3'b000;
    #1 chk("rr_id3", 32'(id1), 32'd0);

    // Stall for three cycles with unit 1 waiting
    step();
    v1 = 3'b010; rd1[9:5] = 5'd7; d1[63:32] = 32'h1234; st1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_ready", 32'(rdy1), 32'd0);
      chk("stall_ptr", 32'(dut1.rr_ptr_q), 32'd1);
      step();
      chk("stall_we", 32'(we1), 32'd0);
    end
    st1 = 1'b0;
    #1 chk("stall_release_ready", 32'(rdy1), 32'h2);
    step();
    v1 = 3'b000;
    #1 chk("stall_waddr", 32'(wa1), 32'd7);
    chk("stall_wdata", wd1, 32'h1234);
    chk("stall_ptr_once", 32'(dut1.rr_ptr_q), 32'd2);
    step();
    #1 chk("stall_ptr_hold", 32'(dut1.rr_ptr_q), 32'd2);

    // x0 destination is consumed without a write
    step();
    v0 = 2'b01; rd0[4:0] = 5'd0; d0[31:0] = 32'hDEAD;
    #1 chk("x0_ready", 32'(rdy0), 32'h1);
    step();
    v0 = 2'b00;
    #1 chk("x0_we", 32'(we0), 32'd0);
    chk("x0_wdata", wd0, 32'd0);
    chk("x0_count", cnt0, 32'd2);
    step();
    #1 chk("x0_count_after", cnt0, 32'd2);

    // Counter wrap
    step();
    force dut0.wb_count_q = 32'hFFFF_FFFE;
    m_cnt[0] = 32'hFFFF_FFFE;
    #1 release dut0.wb_count_q;
    step();
    v0 = 2'b01; rd0[4:0] = 5'd9; d0[31:0] = 32'h55;
    step();
    step();
    #1 chk("wrap_ffffffff", cnt0, 32'hFFFF_FFFF);
    step();
    v0 = 2'b00;
    #1 chk("wrap_zero", cnt0, 32'd0);
    step();
    #1 chk("wrap_one", cnt0, 32'd1);
    step();

    rand_phase(400);

    // Reset in the middle of a continuous stream
    step();
    idle_all();
    v1 = 3'b111; rd1 = {5'd4, 5'd5, 5'd6}; d1 = {32'h40, 32'h50, 32'h60};
    step();
    step();
    rst = 1'b0;
    #1 chk("rst_we", 32'(we1), 32'd0);
    chk("rst_waddr", 32'(wa1), 32'd0);
    chk("rst_wdata", wd1, 32'd0);
    chk("rst_id", 32'(id1), 32'd0);
    chk("rst_count", cnt1, 32'd0);
    chk("rst_ready", 32'(rdy1), 32'd0);
    v1 = 3'b100;
    step();
    step();
    rst = 1'b1;
    v1 = 3'b101;
    #1 chk("rel_unit0_first", 32'(rdy1), 32'h1);
    step();
    v1 = 3'b100;
    #1 chk("rel_unit2", 32'(rdy1), 32'h4);
    chk("rel_id0", 32'(id1), 32'd0);
    step();
    v1 = 3'b000;
    #1 chk("rel_id2", 32'(id1), 32'd2);
    chk("rel_waddr2", 32'(wa1), 32'd4);
    step();

    rand_phase(200);
    step();
    idle_all();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
